// File: rtl/mem_arbiter.sv
// Shares one SRAM port between the IFU (read-only) and the LSU (read/write).
// One transaction in flight at a time; each response goes back only to the requester that issued it.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_valid,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_ready,
    output logic          ifu_rvalid,
    output logic [DW-1:0] ifu_rdata,
    output logic          ifu_err,
    input  logic          lsu_valid,
    input  logic [AW-1:0] lsu_addr,
    input  logic          lsu_wen,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [7:0]    lsu_wmask,
    output logic          lsu_ready,
    output logic          lsu_rvalid,
    output logic [DW-1:0] lsu_rdata,
    output logic          lsu_err,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

    state_t        state, state_nxt;
    owner_t        owner, last_grant;
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;

    assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        state_nxt = state;
        ifu_ready = 1'b0;
        lsu_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (ifu_valid && (!lsu_valid || last_grant == OWN_LSU)) ifu_ready = 1'b1;
                else if (lsu_valid)                                      lsu_ready = 1'b1;
                if (ifu_valid || lsu_valid) state_nxt = S_REQ;
            end
            S_REQ:  if (mem_ready) state_nxt = S_WAIT;
            S_WAIT: if (mem_rvalid || timeout_hit) state_nxt = S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= OWN_IFU;
            last_grant <= OWN_LSU;
            wait_cnt   <= '0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            ifu_rvalid <= 1'b0;
            ifu_rdata  <= '0;
            ifu_err    <= 1'b0;
            lsu_rvalid <= 1'b0;
            lsu_rdata  <= '0;
            lsu_err    <= 1'b0;
        end else begin
            ifu_rvalid <= 1'b0;
            lsu_rvalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ifu_ready) begin
                        owner      <= OWN_IFU;
                        last_grant <= OWN_IFU;
                        mem_valid  <= 1'b1;
                        mem_addr   <= ifu_addr;
                        mem_wen    <= 1'b0;
                        mem_wdata  <= '0;
                        mem_wmask  <= '0;
                    end else if (lsu_ready) begin
                        owner      <= OWN_LSU;
                        last_grant <= OWN_LSU;
                        mem_valid  <= 1'b1;
                        mem_addr   <= lsu_addr;
                        mem_wen    <= lsu_wen;
                        mem_wdata  <= lsu_wdata;
                        mem_wmask  <= lsu_wmask;
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        wait_cnt  <= '0;
                    end
                end
                // A real response in the last allowed cycle beats the timeout.
                S_WAIT: begin
                    if (mem_rvalid || timeout_hit) begin
                        if (owner == OWN_IFU) begin
                            ifu_rvalid <= 1'b1;
                            ifu_rdata  <= mem_rvalid ? mem_rdata : '0;
                            ifu_err    <= ~mem_rvalid;
                        end else begin
                            lsu_rvalid <= 1'b1;
                            lsu_rdata  <= mem_rvalid ? mem_rdata : '0;
                            lsu_err    <= ~mem_rvalid;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a timestamp-based transaction model checked every cycle.
module tb_mem_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ifu_valid, ifu_ready, ifu_rvalid, ifu_err;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_valid, lsu_wen, lsu_ready, lsu_rvalid, lsu_err;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [7:0]    lsu_wmask, mem_wmask;
    logic          mem_valid, mem_ready, mem_wen, mem_rvalid, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ifu_valid(ifu_valid), .ifu_addr(ifu_addr), .ifu_ready(ifu_ready),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_ready(lsu_ready),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: a request is accepted, waits for mem_ready, then the
    // response comes one cycle after mem_rvalid or after TIMEOUT silent cycles.
    logic        m_busy, m_acc, m_owner_lsu, m_last_lsu, m_win_ifu;
    int          m_resp_cyc, m_wait_start;
    logic [31:0] m_addr, m_wdata, m_ifu_rdata, m_lsu_rdata;
    logic        m_wen, m_ifu_err, m_lsu_err, e_resp;
    logic [7:0]  m_wmask;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 1'b0; m_acc = 1'b0; m_owner_lsu = 1'b0; m_last_lsu = 1'b1;
            m_resp_cyc = -1; m_wait_start = 0;
            m_addr = '0; m_wdata = '0; m_wen = 1'b0; m_wmask = '0;
            m_ifu_rdata = '0; m_ifu_err = 1'b0; m_lsu_rdata = '0; m_lsu_err = 1'b0;
        end else begin
            m_win_ifu = ifu_valid && (!lsu_valid || m_last_lsu);
            e_resp    = m_busy && m_acc && (m_resp_cyc == cyc);
            check_bit("model ifu_ready", ifu_ready, !m_busy && m_win_ifu);
            check_bit("model lsu_ready", lsu_ready, !m_busy && lsu_valid && !m_win_ifu);
            check_bit("model busy", busy, m_busy);
            check_bit("model mem_valid", mem_valid, m_busy && !m_acc);
            if (m_busy && !m_acc) begin
                check_word("model mem_addr", mem_addr, m_addr);
                check_bit("model mem_wen", mem_wen, m_wen);
                check_word("model mem_wdata", mem_wdata, m_wdata);
                check_word("model mem_wmask", 32'(mem_wmask), 32'(m_wmask));
            end
            check_bit("model ifu_rvalid", ifu_rvalid, e_resp && !m_owner_lsu);
            check_bit("model lsu_rvalid", lsu_rvalid, e_resp && m_owner_lsu);
            check_word("model ifu_rdata", ifu_rdata, m_ifu_rdata);
            check_bit("model ifu_err", ifu_err, m_ifu_err);
            check_word("model lsu_rdata", lsu_rdata, m_lsu_rdata);
            check_bit("model lsu_err", lsu_err, m_lsu_err);

            if (!m_busy) begin
                if (ifu_valid || lsu_valid) begin
                    m_busy = 1'b1; m_acc = 1'b0; m_resp_cyc = -1;
                    m_owner_lsu = !m_win_ifu;
                    m_last_lsu  = m_owner_lsu;
                    m_addr  = m_owner_lsu ? lsu_addr  : ifu_addr;
                    m_wen   = m_owner_lsu ? lsu_wen   : 1'b0;
                    m_wdata = m_owner_lsu ? lsu_wdata : 32'h0;
                    m_wmask = m_owner_lsu ? lsu_wmask : 8'h0;
                end
            end else if (!m_acc) begin
                if (mem_ready) begin
                    m_acc = 1'b1;
                    m_wait_start = cyc + 1;
                end
            end else if (m_resp_cyc < 0) begin
                if (mem_rvalid || (cyc - m_wait_start == TIMEOUT - 1)) begin
                    m_resp_cyc = cyc + 1;
                    if (m_owner_lsu) begin
                        m_lsu_rdata = mem_rvalid ? mem_rdata : 32'h0;
                        m_lsu_err   = !mem_rvalid;
                    end else begin
                        m_ifu_rdata = mem_rvalid ? mem_rdata : 32'h0;
                        m_ifu_err   = !mem_rvalid;
                    end
                end
            end else if (cyc == m_resp_cyc) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic iv, input logic [31:0] ia,
                                  input logic lv, input logic [31:0] la, input logic lw,
                                  input logic [31:0] wd, input logic [7:0] wm,
                                  input logic mr, input logic mrv, input logic [31:0] mrd);
        ifu_valid = iv; ifu_addr = ia;
        lsu_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = wd; lsu_wmask = wm;
        mem_ready = mr; mem_rvalid = mrv; mem_rdata = mrd;
    endtask

    task automatic idle_inputs();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        next_cycle();
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        idle_inputs();

        // Single IFU fetch with zero-wait memory.
        do_reset();
        check_bit("t1 reset busy", busy, 1'b0);
        check_word("t1 reset ifu_rdata", ifu_rdata, 32'h0);
        apply_stimulus(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 32'h0);
        mid();
        check_bit("t1 ifu_ready c0", ifu_ready, 1'b1);
        check_bit("t1 lsu_ready c0", lsu_ready, 1'b0);
        next_cycle();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 32'h0);
        mid();
        check_bit("t1 mem_valid c1", mem_valid, 1'b1);
        check_word("t1 mem_addr c1", mem_addr, 32'h8000_0000);
        check_bit("t1 mem_wen c1", mem_wen, 1'b0);
        next_cycle();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b1, 1'b1, 32'h0000_0413);
        mid();
        check_bit("t1 ifu_rvalid c2", ifu_rvalid, 1'b0);
        next_cycle();
        idle_inputs();
        mid();
        check_bit("t1 ifu_rvalid c3", ifu_rvalid, 1'b1);
        check_word("t1 ifu_rdata c3", ifu_rdata, 32'h0000_0413);
        check_bit("t1 ifu_err c3", ifu_err, 1'b0);
        check_bit("t1 lsu_rvalid c3", lsu_rvalid, 1'b0);
        next_cycle();
        mid();
        check_bit("t1 ifu_rvalid c4", ifu_rvalid, 1'b0);

        // Both requesters held high: strict alternation starting with the IFU.
        do_reset();
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 4; k++) begin
                apply_stimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 8'h0,
                               1'b1, 1'b1, 32'hA000_0000 + 32'(t * 4 + k));
                mid();
                if (k == 0) begin
                    check_bit("t2 ifu grant", ifu_ready, (t % 2) == 0);
                    check_bit("t2 lsu grant", lsu_ready, (t % 2) == 1);
                end
                if (k == 3) begin
                    check_bit("t2 ifu_rvalid", ifu_rvalid, (t % 2) == 0);
                    check_bit("t2 lsu_rvalid", lsu_rvalid, (t % 2) == 1);
                    if (t % 2 == 0) check_word("t2 ifu_rdata", ifu_rdata, 32'hA000_0000 + 32'(t * 4 + 2));
                    else            check_word("t2 lsu_rdata", lsu_rdata, 32'hA000_0000 + 32'(t * 4 + 2));
                end
                next_cycle();
            end
        end

        // LSU write with a slow mem_ready; the IFU must wait until the port is free.
        do_reset();
        apply_stimulus(1'b0, 32'h0, 1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F, 1'b0, 1'b0, 32'h0);
        mid();
        check_bit("t3 lsu_ready", lsu_ready, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            apply_stimulus(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, i == 4, 1'b0, 32'h0);
            mid();
            check_bit("t3 mem_valid", mem_valid, 1'b1);
            check_word("t3 mem_addr", mem_addr, 32'h8000_1000);
            check_bit("t3 mem_wen", mem_wen, 1'b1);
            check_word("t3 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            check_word("t3 mem_wmask", 32'(mem_wmask), 32'h0F);
            check_bit("t3 ifu_ready busy", ifu_ready, 1'b0);
        end
        for (int i = 5; i <= 8; i++) begin
            next_cycle();
            apply_stimulus(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0, i == 6, 32'h0);
            mid();
            check_bit("t3 lsu_rvalid", lsu_rvalid, i == 7);
            check_bit("t3 ifu_ready", ifu_ready, i == 8);
        end
        mid();
        check_bit("t3 lsu_err", lsu_err, 1'b0);

        // Normal LSU read, then a read that times out, then stray mem_rvalid in IDLE.
        do_reset();
        apply_stimulus(1'b0, 32'h0, 1'b1, 32'h400, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 32'h0);
        mid();
        check_bit("t4 lsu_ready a", lsu_ready, 1'b1);
        next_cycle();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 32'h0);
        next_cycle();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b1, 1'b1, 32'h1234_5678);
        next_cycle();
        idle_inputs();
        mid();
        check_bit("t4 lsu_rvalid a", lsu_rvalid, 1'b1);
        check_word("t4 lsu_rdata a", lsu_rdata, 32'h1234_5678);
        next_cycle();
        apply_stimulus(1'b0, 32'h0, 1'b1, 32'h404, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 32'h0);
        mid();
        check_bit("t4 lsu_ready b", lsu_ready, 1'b1);
        for (int i = 5; i <= 9; i++) begin
            next_cycle();
            apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 32'h0);
            mid();
            check_bit("t4 no early response", lsu_rvalid, 1'b0);
        end
        next_cycle();
        mid();
        check_bit("t4 timeout rvalid", lsu_rvalid, 1'b1);
        check_bit("t4 timeout err", lsu_err, 1'b1);
        check_word("t4 timeout rdata", lsu_rdata, 32'h0);
        for (int i = 11; i <= 14; i++) begin
            next_cycle();
            apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0, i <= 12, 32'h7777_7777);
            mid();
            check_bit("t4 stray lsu_rvalid", lsu_rvalid, 1'b0);
            check_bit("t4 stray ifu_rvalid", ifu_rvalid, 1'b0);
            check_bit("t4 stray busy", busy, 1'b0);
        end

        // mem_rvalid in the last allowed WAIT cycle wins over the timeout.
        next_cycle();
        apply_stimulus(1'b0, 32'h0, 1'b1, 32'h408, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 32'h0);
        mid();
        check_bit("t6 lsu_ready", lsu_ready, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b1, k == 5, 32'h0BAD_C0DE);
            mid();
            check_bit("t6 no early response", lsu_rvalid, 1'b0);
        end
        next_cycle();
        idle_inputs();
        mid();
        check_bit("t6 lsu_rvalid", lsu_rvalid, 1'b1);
        check_bit("t6 lsu_err", lsu_err, 1'b0);
        check_word("t6 lsu_rdata", lsu_rdata, 32'h0BAD_C0DE);

        // Reset asserted in the middle of an IFU wait.
        do_reset();
        for (int k = 0; k <= 6; k++) begin
            apply_stimulus(k <= 4, 32'h500, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b1, k == 2, 32'hCAFE_F00D);
            mid();
            if (k == 0 || k == 4) check_bit("t5 ifu_ready", ifu_ready, 1'b1);
            if (k == 3) check_word("t5 ifu_rdata", ifu_rdata, 32'hCAFE_F00D);
            next_cycle();
        end
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 32'h0);
        check_bit("t5 busy before reset", busy, 1'b1);
        #1 rst = 1'b0;
        #1;
        check_bit("t5 async busy", busy, 1'b0);
        check_bit("t5 async mem_valid", mem_valid, 1'b0);
        check_word("t5 async mem_addr", mem_addr, 32'h0);
        check_word("t5 async ifu_rdata", ifu_rdata, 32'h0);
        check_bit("t5 async ifu_err", ifu_err, 1'b0);
        check_bit("t5 async ifu_rvalid", ifu_rvalid, 1'b0);
        check_word("t5 async lsu_rdata", lsu_rdata, 32'h0);
        check_bit("t5 async lsu_rvalid", lsu_rvalid, 1'b0);
        mid();
        #2 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b1, k < 2, 32'h5555_5555);
            mid();
            check_bit("t5 late ifu_rvalid", ifu_rvalid, 1'b0);
        end
        next_cycle();
        apply_stimulus(1'b1, 32'h600, 1'b1, 32'h700, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 32'h0);
        mid();
        check_bit("t5 first tie ifu", ifu_ready, 1'b1);
        check_bit("t5 first tie lsu", lsu_ready, 1'b0);

        next_cycle();
        idle_inputs();
        repeat (6) next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
